// File: rtl/fifo_read_ctrl_pkg.sv
// Shared definitions for the packet FIFO pointer controllers: FSM encodings,
// default geometry and the binary-to-Gray helper used by both sides.
package fifo_read_ctrl_pkg;

  localparam int DEF_DEPTH  = 3;
  localparam int DEF_PTR_SZ = 2;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_EMPTY = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_read_ctrl.sv
// Read-side pointer controller: tracks empty against the synchronized write
// address, strobes one memory read per accepted request, publishes Gray address.
module fifo_read_ctrl
  import fifo_read_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_SZ = DEF_PTR_SZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rinc,
  input  logic [PTR_SZ-1:0] rq2_waddr,
  output logic              rempty,
  output logic              read_en,
  output logic [PTR_SZ-1:0] raddr,
  output logic [PTR_SZ-1:0] raddr_gray,
  output logic              rvalid
);

  localparam logic [PTR_SZ-1:0] LAST_ADDR = PTR_SZ'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [PTR_SZ-1:0] r_raddr;
  logic [PTR_SZ-1:0] r_raddr_gray;
  logic              r_rempty;
  logic              r_rvalid;
  logic              w_read_en;
  logic [PTR_SZ-1:0] w_raddr_next;
  logic [PTR_SZ-1:0] w_raddr_next_gray;

  // Wrap follows DEPTH, so non-power-of-two depths skip the unused codes.
  always_comb begin
    w_read_en         = rinc && (r_state == ST_READ);
    w_raddr_next      = (r_raddr == LAST_ADDR) ? '0 : r_raddr + 1'b1;
    w_raddr_next_gray = PTR_SZ'(bin2gray(32'(w_raddr_next)));
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT:  w_next_state = ST_EMPTY;
      ST_EMPTY: if (rq2_waddr != r_raddr) w_next_state = ST_READ;
      ST_READ: begin
        // Second arm only fires if the writer misbehaves; kept as a safety net.
        if (w_read_en && (w_raddr_next == rq2_waddr))
          w_next_state = ST_EMPTY;
        else if (!w_read_en && (rq2_waddr == r_raddr))
          w_next_state = ST_EMPTY;
      end
      default:  w_next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_INIT;
      r_raddr      <= '0;
      r_raddr_gray <= '0;
      r_rempty     <= 1'b1;
      r_rvalid     <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_rempty <= (w_next_state != ST_READ);
      r_rvalid <= w_read_en;
      if (w_read_en) begin
        r_raddr      <= w_raddr_next;
        r_raddr_gray <= w_raddr_next_gray;
      end
    end
  end

  assign rempty     = r_rempty;
  assign read_en    = w_read_en;
  assign raddr      = r_raddr;
  assign raddr_gray = r_raddr_gray;
  assign rvalid     = r_rvalid;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl (DEPTH=4): occupancy-level reference model
// compared every cycle, plus literal expectations along the directed sequence.
module tb_fifo_read_ctrl;

  localparam int DEPTH  = 4;
  localparam int PTR_SZ = 2;

  logic              clk;
  logic              rst;
  logic              rinc;
  logic [PTR_SZ-1:0] rq2_waddr;
  logic              rempty;
  logic              read_en;
  logic [PTR_SZ-1:0] raddr;
  logic [PTR_SZ-1:0] raddr_gray;
  logic              rvalid;

  int n_chk  = 0;
  int n_pass = 0;

  fifo_read_ctrl #(.DEPTH(DEPTH), .PTR_SZ(PTR_SZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .rinc       (rinc),
    .rq2_waddr  (rq2_waddr),
    .rempty     (rempty),
    .read_en    (read_en),
    .raddr      (raddr),
    .raddr_gray (raddr_gray),
    .rvalid     (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: the FIFO is empty when the read pointer has caught up
  // with the write pointer; a request is honoured only while not empty.
  int m_raddr  = 0;
  bit m_rempty = 1'b1;
  bit m_rvalid = 1'b0;
  bit m_init   = 1'b1;
  bit m_valid  = 1'b0;

  always @(posedge clk) begin
    bit rd;
    int n;
    if (!rst) begin
      m_raddr  = 0;
      m_rempty = 1'b1;
      m_rvalid = 1'b0;
      m_init   = 1'b1;
    end else begin
      rd       = rinc && !m_rempty;
      n        = rd ? (m_raddr + 1) % DEPTH : m_raddr;
      m_rempty = m_init ? 1'b1 : (n == int'(rq2_waddr));
      m_init   = 1'b0;
      m_rvalid = rd;
      m_raddr  = n;
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_rempty",  32'(rempty),     32'(m_rempty));
      check("model_raddr",   32'(raddr),      32'(m_raddr));
      check("model_gray",    32'(raddr_gray), 32'(m_raddr ^ (m_raddr >> 1)));
      check("model_rvalid",  32'(rvalid),     32'(m_rvalid));
      check("model_read_en", 32'(read_en),    32'(rinc && !m_rempty));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    rinc      = 1'b1;
    rq2_waddr = 2'd2;
    step();
    step();
    #1;
    check("rst_rempty",  32'(rempty),     32'd1);
    check("rst_raddr",   32'(raddr),      32'd0);
    check("rst_gray",    32'(raddr_gray), 32'd0);
    check("rst_read_en", 32'(read_en),    32'd0);
    check("rst_rvalid",  32'(rvalid),     32'd0);

    rst       = 1'b1;
    rinc      = 1'b0;
    rq2_waddr = 2'd0;
    step();
    check("init_done_rempty", 32'(rempty), 32'd1);

    // Requests against an empty FIFO are dropped
    rinc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("guard_read_en", 32'(read_en), 32'd0);
      step();
      check("guard_raddr",  32'(raddr),  32'd0);
      check("guard_rvalid", 32'(rvalid), 32'd0);
    end

    rinc      = 1'b0;
    rq2_waddr = 2'd1;
    step();
    check("single_rempty_low", 32'(rempty), 32'd0);
    rinc = 1'b1;
    #1;
    check("single_read_en", 32'(read_en), 32'd1);
    step();
    rinc = 1'b0;
    check("single_raddr",  32'(raddr),      32'd1);
    check("single_gray",   32'(raddr_gray), 32'd1);
    check("single_rvalid", 32'(rvalid),     32'd1);
    check("single_rempty", 32'(rempty),     32'd1);
    step();
    check("single_rvalid_drop", 32'(rvalid), 32'd0);

    // Three entries at addresses 1,2,3; drain crosses the wrap
    rq2_waddr = 2'd0;
    step();
    check("burst_rempty_low", 32'(rempty), 32'd0);
    rinc = 1'b1;
    step();
    check("burst_raddr2", 32'(raddr), 32'd2);
    check("burst_gray3",  32'(raddr_gray), 32'd3);
    step();
    check("burst_raddr3", 32'(raddr), 32'd3);
    check("burst_gray2",  32'(raddr_gray), 32'd2);
    step();
    check("burst_raddr0", 32'(raddr), 32'd0);
    check("burst_gray0",  32'(raddr_gray), 32'd0);
    check("burst_rvalid", 32'(rvalid), 32'd1);
    check("burst_rempty", 32'(rempty), 32'd1);
    #1;
    check("burst_read_en_empty", 32'(read_en), 32'd0);
    step();
    check("burst_rvalid_end", 32'(rvalid), 32'd0);

    // Refill: two entries, then two more as soon as the last one is consumed
    rinc      = 1'b0;
    rq2_waddr = 2'd2;
    step();
    check("refill_rempty_low", 32'(rempty), 32'd0);
    rinc = 1'b1;
    step();
    check("refill_raddr1", 32'(raddr), 32'd1);
    step();
    check("refill_drained", 32'(rempty), 32'd1);
    check("refill_raddr2",  32'(raddr),  32'd2);
    rq2_waddr = 2'd0;
    step();
    check("refill_rempty_again", 32'(rempty), 32'd0);
    #1;
    check("refill_read_en", 32'(read_en), 32'd1);
    step();
    check("refill_raddr3", 32'(raddr), 32'd3);
    step();
    check("refill_raddr0", 32'(raddr),  32'd0);
    check("refill_empty",  32'(rempty), 32'd1);

    // Reset while a read is being issued
    rinc      = 1'b0;
    rq2_waddr = 2'd2;
    step();
    rinc = 1'b1;
    step();
    #1;
    check("midrst_read_en", 32'(read_en), 32'd1);
    rst = 1'b0;
    step();
    check("midrst_raddr",  32'(raddr),  32'd0);
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_rempty", 32'(rempty), 32'd1);
    rst  = 1'b1;
    rinc = 1'b0;
    step();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
